// File: rtl/multdiv_pkg.sv
// Shared constants for the multiply/divide issue controller:
// FSM state encoding, default WAIT timeout and unit select codes.
package multdiv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int TIMEOUT_DEF = 40;

   // Latched is_div value selects the unit
   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/multdiv_issue_ctrl.sv
// Execute-stage initiator for the multi-cycle multiplier/divider.
// Latches one mult/div instruction, strobes the matching unit, stalls the
// pipeline until the unit reports ready, then pulses the result to writeback.
// Optional: define MULTDIV_TIMEOUT_EN to force completion (wb_exception=1,
// wb_data=0) after TIMEOUT WAIT cycles without ready.
module multdiv_issue_ctrl
   import multdiv_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int RD_W    = 5
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            issue_valid,
   input  logic            issue_is_div,
   input  logic [31:0]     issue_opA,
   input  logic [31:0]     issue_opB,
   input  logic [RD_W-1:0] issue_rd,
   output logic            stall,
   output logic            busy,
   output logic [RD_W-1:0] busy_rd,
   output logic [31:0]     data_operandA,
   output logic [31:0]     data_operandB,
   output logic            ctrl_MULT,
   output logic            ctrl_DIV,
   input  logic [31:0]     data_result,
   input  logic            data_exception,
   input  logic            data_resultRDY,
   output logic            wb_valid,
   output logic [RD_W-1:0] wb_rd,
   output logic [31:0]     wb_data,
   output logic            wb_exception
);

   state_t            r_state;
   state_t            w_next;
   logic [31:0]       r_opA;
   logic [31:0]       r_opB;
   logic [RD_W-1:0]   r_rd;
   logic              r_is_div;
   logic [RD_W-1:0]   r_wb_rd;
   logic [31:0]       r_wb_data;
   logic              r_wb_exc;
   logic              w_accept;
   logic              w_ready;
   logic              w_timeout;

   assign w_accept = (r_state == IDLE) && issue_valid;
   // Ready only counts in WAIT; stray ready elsewhere is dropped
   assign w_ready  = (r_state == WAIT) && data_resultRDY;

`ifdef MULTDIV_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] r_tmo_cnt;

   // WAIT-cycle counter, cleared in START so it starts at zero on WAIT entry
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_tmo_cnt <= '0;
      else if (r_state == START)
         r_tmo_cnt <= '0;
      else if (r_state == WAIT)
         r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
   end

   // Fires on the TIMEOUT-th WAIT cycle; a simultaneous ready takes priority
   assign w_timeout = (r_state == WAIT) && !data_resultRDY &&
                      (r_tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
   assign w_timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (issue_valid) w_next = START;
         START:   w_next = WAIT;
         WAIT:    if (w_ready || w_timeout) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Output decode from state
   always_comb begin
      stall     = 1'b0;
      busy      = 1'b0;
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      wb_valid  = 1'b0;
      case (r_state)
         IDLE:  stall = issue_valid;
         START: begin
            stall     = 1'b1;
            busy      = 1'b1;
            ctrl_DIV  = (r_is_div == OP_DIV);
            ctrl_MULT = (r_is_div == OP_MULT);
         end
         WAIT: begin
            stall = 1'b1;
            busy  = 1'b1;
         end
         DONE: begin
            busy     = 1'b1;
            wb_valid = 1'b1;
         end
         default: ;
      endcase
   end

   // Operand/destination latch; held from START through DONE
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_opA    <= '0;
         r_opB    <= '0;
         r_rd     <= '0;
         r_is_div <= 1'b0;
      end else if (w_accept) begin
         r_opA    <= issue_opA;
         r_opB    <= issue_opB;
         r_rd     <= issue_rd;
         r_is_div <= issue_is_div;
      end
   end

   // Writeback capture; values persist until the next completion
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wb_rd   <= '0;
         r_wb_data <= '0;
         r_wb_exc  <= 1'b0;
      end else if (w_ready) begin
         r_wb_rd   <= r_rd;
         r_wb_data <= data_result;
         r_wb_exc  <= data_exception;
      end else if (w_timeout) begin
         r_wb_rd   <= r_rd;
         r_wb_data <= '0;
         r_wb_exc  <= 1'b1;
      end
   end

   assign busy_rd       = busy ? r_rd : '0;
   assign data_operandA = r_opA;
   assign data_operandB = r_opB;
   assign wb_rd         = r_wb_rd;
   assign wb_data       = r_wb_data;
   assign wb_exception  = r_wb_exc;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Scoreboard bench for multdiv_issue_ctrl: expected writebacks are queued at
// issue and popped by a monitor whenever wb_valid is seen.
module tb_multdiv_issue_ctrl;

   localparam int RD_W    = 5;
   localparam int TIMEOUT = 40;

   logic            clock = 1'b0;
   logic            reset_n;
   logic            issue_valid;
   logic            issue_is_div;
   logic [31:0]     issue_opA;
   logic [31:0]     issue_opB;
   logic [RD_W-1:0] issue_rd;
   logic            stall;
   logic            busy;
   logic [RD_W-1:0] busy_rd;
   logic [31:0]     data_operandA;
   logic [31:0]     data_operandB;
   logic            ctrl_MULT;
   logic            ctrl_DIV;
   logic [31:0]     data_result;
   logic            data_exception;
   logic            data_resultRDY;
   logic            wb_valid;
   logic [RD_W-1:0] wb_rd;
   logic [31:0]     wb_data;
   logic            wb_exception;

   typedef struct {
      logic [RD_W-1:0] rd;
      logic [31:0]     data;
      logic            exc;
   } wb_exp_t;

   wb_exp_t sb_q[$];
   int checks = 0;
   int errors = 0;

   multdiv_issue_ctrl #(.TIMEOUT(TIMEOUT), .RD_W(RD_W)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .issue_valid    (issue_valid),
      .issue_is_div   (issue_is_div),
      .issue_opA      (issue_opA),
      .issue_opB      (issue_opB),
      .issue_rd       (issue_rd),
      .stall          (stall),
      .busy           (busy),
      .busy_rd        (busy_rd),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .wb_valid       (wb_valid),
      .wb_rd          (wb_rd),
      .wb_data        (wb_data),
      .wb_exception   (wb_exception)
   );

   always #5 clock = ~clock;

   // Writeback monitor: every wb_valid must match the oldest queued expectation
   always @(negedge clock) begin
      if (wb_valid === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL wb_unexpected: got rd=%0d data=%h exc=%b, required no writeback",
                     wb_rd, wb_data, wb_exception);
         end else begin
            wb_exp_t e;
            e = sb_q.pop_front();
            if (wb_rd !== e.rd || wb_data !== e.data || wb_exception !== e.exc) begin
               errors++;
               $display("FAIL wb_result: got rd=%0d data=%h exc=%b, required rd=%0d data=%h exc=%b",
                        wb_rd, wb_data, wb_exception, e.rd, e.data, e.exc);
            end
         end
      end
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   // One full operation. Called at a negedge with the DUT in IDLE; returns at
   // the negedge of the following IDLE cycle, so calls can be chained.
   task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                         input logic [RD_W-1:0] rd, input int lat,
                         input logic [31:0] res, input logic exc, input logic early);
      logic [31:0] old_wb;
      wb_exp_t     e;
      int          n_div;
      int          n_mult;
      old_wb = wb_data;
      n_div  = 0;
      n_mult = 0;
      issue_valid    = 1'b1;
      issue_is_div   = is_div;
      issue_opA      = a;
      issue_opB      = b;
      issue_rd       = rd;
      data_resultRDY = early;
      data_result    = res;
      data_exception = exc;
      e.rd = rd; e.data = res; e.exc = exc;
      sb_q.push_back(e);
      #1;
      chk("stall_issue", {31'd0, stall}, 32'd1);
      // START
      @(negedge clock);
      chk("strobe_div",  {31'd0, ctrl_DIV},  {31'd0, is_div});
      chk("strobe_mult", {31'd0, ctrl_MULT}, {31'd0, ~is_div});
      chk("busy_rd",     {27'd0, busy_rd},   {27'd0, rd});
      chk("operandA",    data_operandA, a);
      chk("wb_no_capture_start", wb_data, old_wb);
      // WAIT cycles before ready
      for (int k = 1; k < lat; k++) begin
         @(negedge clock);
         data_resultRDY = 1'b0;
         data_result    = $urandom;
         data_exception = 1'b0;
         if (stall !== 1'b1 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_stall: got stall=%b wb_valid=%b, required 1/0", stall, wb_valid);
         end
         if (ctrl_DIV) n_div++;
         if (ctrl_MULT) n_mult++;
      end
      chk("strobe_extra", n_div + n_mult, 32'd0);
      // Ready cycle
      @(negedge clock);
      data_resultRDY = 1'b1;
      data_result    = res;
      data_exception = exc;
      #1;
      chk("stall_ready_cycle", {31'd0, stall}, 32'd1);
      // DONE: issue_valid still high and must be ignored
      @(negedge clock);
      data_resultRDY = 1'b0;
      data_result    = $urandom;
      chk("wb_valid_done",  {31'd0, wb_valid}, 32'd1);
      chk("stall_done",     {31'd0, stall},    32'd0);
      chk("operandB_done",  data_operandB, b);
      // Back in IDLE
      @(negedge clock);
      issue_valid = 1'b0;
      #1;
      chk("busy_idle", {31'd0, busy}, 32'd0);
      chk("wb_hold",   wb_data, res);
   endtask

   task automatic test_reset();
      reset_n        = 1'b0;
      issue_valid    = 1'b0;
      issue_is_div   = 1'b0;
      issue_opA      = '0;
      issue_opB      = '0;
      issue_rd       = '0;
      data_result    = '0;
      data_exception = 1'b0;
      data_resultRDY = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_busy",  {31'd0, busy},  32'd0);
      chk("rst_ctrl",  {30'd0, ctrl_DIV, ctrl_MULT}, 32'd0);
      chk("rst_wb",    {wb_valid, wb_exception, 25'd0, wb_rd}, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_opA",   data_operandA, 32'd0);
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_divide();
      run_op(1'b1, 32'd100, 32'd7, 5'd5, 34, 32'd14, 1'b0, 1'b0);
   endtask

   task automatic test_div_by_zero();
      run_op(1'b1, 32'd55, 32'd0, 5'd9, 34, 32'd0, 1'b1, 1'b0);
   endtask

   task automatic test_multiply();
      run_op(1'b0, 32'hFFFF_FFFD, 32'd5, 5'd12, 17, 32'hFFFF_FFF1, 1'b0, 1'b0);
   endtask

   task automatic test_stray_ready();
      int bad;
      bad = 0;
      data_resultRDY = 1'b1;
      data_result    = 32'hDEAD_BEEF;
      repeat (3) begin
         @(negedge clock);
         if (wb_valid !== 1'b0 || busy !== 1'b0) bad++;
      end
      chk("stray_idle", bad, 32'd0);
      // Ready held from issue through START: first WAIT cycle captures
      run_op(1'b0, 32'd6, 32'd7, 5'd3, 1, 32'd42, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      run_op(1'b0, 32'd2, 32'd3, 5'd1, 4, 32'd6, 1'b0, 1'b0);
      run_op(1'b1, 32'd9, 32'd3, 5'd31, 2, 32'd3, 1'b0, 1'b0);
   endtask

   task automatic test_reset_midop();
      int bad;
      bad = 0;
      issue_valid  = 1'b1;
      issue_is_div = 1'b1;
      issue_opA    = 32'd77;
      issue_opB    = 32'd11;
      issue_rd     = 5'd17;
      repeat (5) @(negedge clock);
      chk("midop_busy", {31'd0, busy}, 32'd1);
      reset_n     = 1'b0;
      issue_valid = 1'b0;
      #1;
      chk("midop_rst_out", {stall, busy, ctrl_DIV, ctrl_MULT, wb_valid, wb_exception, 21'd0, busy_rd}, 32'd0);
      chk("midop_rst_wb", wb_data | data_operandA | data_operandB | {27'd0, wb_rd}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      // The unit finishes later; its ready must be ignored
      data_resultRDY = 1'b1;
      data_result    = 32'd7;
      repeat (3) begin
         @(negedge clock);
         if (wb_valid !== 1'b0 || busy !== 1'b0) bad++;
      end
      data_resultRDY = 1'b0;
      chk("midop_late_ready", bad, 32'd0);
   endtask

`ifdef MULTDIV_TIMEOUT_EN
   task automatic test_timeout();
      wb_exp_t e;
      int n;
      issue_valid    = 1'b1;
      issue_is_div   = 1'b1;
      issue_opA      = 32'd1;
      issue_opB      = 32'd2;
      issue_rd       = 5'd20;
      data_resultRDY = 1'b0;
      e.rd = 5'd20; e.data = 32'd0; e.exc = 1'b1;
      sb_q.push_back(e);
      @(negedge clock);
      n = 0;
      while (wb_valid !== 1'b1 && n < 200) begin
         @(negedge clock);
         n++;
      end
      chk("timeout_cycles", n, TIMEOUT + 1);
      chk("timeout_stall",  {31'd0, stall}, 32'd0);
      @(negedge clock);
      issue_valid = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_divide();
      test_div_by_zero();
      test_multiply();
      test_stray_ready();
      test_back_to_back();
      test_reset_midop();
`ifdef MULTDIV_TIMEOUT_EN
      test_timeout();
`endif
      repeat (3) @(negedge clock);
      chk("scoreboard_drained", sb_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multdiv_issue_ctrl.md
# multdiv_issue_ctrl

Initiator side of the multiply/divide start/ready handshake. Sits in the execute stage between the pipeline and the multi-cycle multiplier/divider units. Latches a mult or div instruction's operands and destination, pulses the matching start strobe, and stalls the pipeline until the unit raises its ready flag. It then hands result, exception flag and destination register to writeback as a one-cycle pulse.

## Interface
Parameters:
- TIMEOUT, 40, max WAIT cycles before forced completion (only with MULTDIV_TIMEOUT_EN)
- RD_W, 5, destination register index width

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  mult/div instruction present in X stage
- issue_is_div  in  1  1 = divide, 0 = multiply
- issue_opA  in  32  operand A (dividend / multiplicand)
- issue_opB  in  32  operand B (divisor / multiplier)
- issue_rd  in  RD_W  destination register
- stall  out  1  freeze F/D/X pipeline registers
- busy  out  1  operation outstanding, for hazard detection
- busy_rd  out  RD_W  destination of outstanding operation
- data_operandA  out  32  registered operand A to units
- data_operandB  out  32  registered operand B to units
- ctrl_MULT  out  1  one-cycle start strobe, multiplier
- ctrl_DIV  out  1  one-cycle start strobe, divider
- data_result  in  32  unit result, selected by latched op
- data_exception  in  1  unit exception, selected by latched op
- data_resultRDY  in  1  unit ready, selected by latched op
- wb_valid  out  1  one-cycle writeback pulse
- wb_rd  out  RD_W  writeback destination
- wb_data  out  32  writeback data
- wb_exception  out  1  writeback exception flag

## Operation
- FSM states: IDLE, START, WAIT, DONE.
- IDLE: issue_valid=1 → latch opA, opB, rd, is_div. Next state START.
- START: exactly one of ctrl_DIV/ctrl_MULT high, per latched is_div. data_resultRDY is ignored. Next state WAIT.
- WAIT: data_resultRDY=1 → capture data_result and data_exception into wb_data/wb_exception. Next state DONE.
- DONE: wb_valid=1. Next state is always IDLE. issue_valid is ignored, because it is still the same instruction.
- stall = issue_valid in IDLE, or state ∈ {START, WAIT}. stall is low in DONE, so the instruction leaves X at the end of DONE.
- busy = state ≠ IDLE. busy_rd = latched rd while busy, else 0.
- data_operandA/B stay constant from START until DONE inclusive. Units compute exception flags combinationally from the operands.
- wb_rd/wb_data/wb_exception hold their values until the next capture.
- Reset values: all outputs 0, state IDLE, latched registers 0.
- Reset mid-operation: returns to IDLE immediately with no writeback. A unit still running is not reset; its later ready is ignored in IDLE.
- Ready in IDLE, START or DONE is ignored.

## Timing
- Issue sampled at edge T → START during T+1 (strobe high one cycle) → WAIT from T+2.
- Ready high in cycle N → DONE in N+1 with wb_valid high → IDLE in N+2. A new issue can be accepted in N+2.
- Total stall cycles = N − T + 1.
- Back-to-back operations: at least 4 cycles apart (IDLE, START, WAIT, DONE).

## Configuration
- MULTDIV_TIMEOUT_EN defined: a counter clears on entering WAIT and increments each WAIT cycle.
  - Count reaching TIMEOUT with no ready → DONE with wb_data=0, wb_exception=1.
  - Ready and timeout in the same cycle → ready wins.
- Undefined: no counter; WAIT lasts until ready, possibly forever.

## Structure
- Package multdiv_pkg holds:
  - state encoding constants (IDLE=2'd0, START=2'd1, WAIT=2'd2, DONE=2'd3)
  - TIMEOUT default
  - OP_MULT/OP_DIV select constants
- Single module, no sub-module. The timeout counter is inline under the macro.

## Test plan
- Divide: issue opA=100, opB=7, rd=5, is_div=1. Model unit raises ready 34 cycles after ctrl_DIV with result 14. Expect:
  - ctrl_DIV one cycle, ctrl_MULT never
  - stall held throughout
  - wb_valid one cycle with wb_rd=5, wb_data=14, wb_exception=0
- Divide by zero: opB=0, model raises ready with data_exception=1, result 0. Expect wb_exception=1, wb_data=0.
- Multiply: opA=−3, opB=5, ready after 17 cycles with result −15. Expect ctrl_MULT pulse and wb_data=32'hFFFFFFF1.
- Stray ready: ready asserted during IDLE and during START. Expect no capture and no wb_valid. With ready held high through START, the first WAIT cycle captures.
- Reset mid-op: reset_n low during WAIT. Expect all outputs 0 and no wb_valid; a later ready pulse is ignored.
- Timeout (MULTDIV_TIMEOUT_EN, TIMEOUT=40): ready never arrives. Expect DONE with wb_exception=1 and wb_data=0, and stall released the same cycle.
